// File: rtl/uart_fifo_loop.sv
// UART receive-to-transmit loopback: received bytes are queued in a circular FIFO
// and replayed to a byte transmitter one at a time, in arrival order.
module uart_fifo_loop #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              recv_done,
  input  logic [7:0]        recv_data,
  input  logic              tx_busy,
  output logic              send_en,
  output logic [7:0]        send_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic [2:0]        o_dbg_state
);

  // Handshake: recv_done is a one-cycle strobe qualifying recv_data (no back-pressure,
  // a byte arriving while full is dropped); send_en is a one-cycle start pulse with
  // send_data already valid, and the transmitter owns the line while tx_busy=1.

  // o_dbg_state encoding: 0 IDLE, 1 LOAD, 2 PULSE, 3 WAIT_BUSY, 4 WAIT_DONE.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_PULSE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] C_FULL = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic [7:0]        r_pop_data;
  logic [7:0]        r_send_data;
  logic [2:0]        r_to_cnt;
  state_t            r_state;

  state_t            w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_send_en;
  logic [ADDR_W:0]   w_count_nxt;

  // A full FIFO drops the byte even when a pop frees a slot in the same cycle.
  assign w_push = recv_done && !r_full;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Storage is never reset; only the pointers and count define what is valid.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= recv_data;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_pop_data <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_pop_data <= r_mem[r_rd_ptr];
      end
      if (recv_done && r_full) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // FSM: state register, timeout counter and the transmit data register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= 3'd0;
      r_send_data <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_WAIT_BUSY) begin
        r_to_cnt <= r_to_cnt + 3'd1;
      end else begin
        r_to_cnt <= 3'd0;
      end
      if (w_load) begin
        r_send_data <= r_pop_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && !tx_busy) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD:  w_state_nxt = S_PULSE;
      S_PULSE: w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        // Eight idle cycles without busy means the start was missed; move on anyway.
        if (tx_busy || (r_to_cnt == 3'd7)) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_send_en = 1'b0;
    case (r_state)
      S_IDLE:  w_pop     = !r_empty && !tx_busy;
      S_LOAD:  w_load    = 1'b1;
      S_PULSE: w_send_en = 1'b1;
      default: ;
    endcase
  end

  assign send_en     = w_send_en;
  assign send_data   = r_send_data;
  assign fifo_full   = r_full;
  assign fifo_empty  = r_empty;
  assign fill_level  = r_count;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_fifo_loop.sv
// Directed and randomized checks of uart_fifo_loop against a byte-queue model
// of what the transmitter must eventually see.
module tb_uart_fifo_loop;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  logic              sys_clk;
  logic              sys_rst;
  logic              recv_done;
  logic [7:0]        recv_data;
  logic              tx_busy;
  logic              send_en;
  logic [7:0]        send_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W:0]   fill_level;
  logic              overflow;
  logic [2:0]        o_dbg_state;

  int total = 0;
  int bad = 0;
  int n_sends = 0;
  int tx_mode = 1;     // 0: never busy, 1: busy for busy_len cycles, 2: random length
  int busy_len = 20;
  int busy_left = 0;
  logic prev_en = 1'b0;
  logic [7:0] mon_want;
  logic [7:0] exp_q[$];

  uart_fifo_loop #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .recv_done   (recv_done),
    .recv_data   (recv_data),
    .tx_busy     (tx_busy),
    .send_en     (send_en),
    .send_data   (send_data),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and reset values
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h required=%0h", tag, got, want);
    end
  endtask

  // Transmitter model: raises busy right after a start pulse.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        tx_busy   = 1'b0;
        busy_left = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end else if (send_en && tx_mode != 0) begin
        busy_left = (tx_mode == 2) ? int'($urandom_range(1, 15)) : busy_len;
        tx_busy   = 1'b1;
      end
    end
  end

  // Scoreboard: every start pulse must carry the next expected byte, for one cycle only.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        prev_en = 1'b0;
      end else begin
        if (send_en) begin
          n_sends++;
          chk("send_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            mon_want = exp_q.pop_front();
            chk("send_data", 32'(send_data), 32'(mon_want));
          end
          chk("send_en_width", 32'(prev_en), 32'd0);
        end
        prev_en = send_en;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit accept);
    recv_done = 1'b1;
    recv_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge sys_clk);
    recv_done = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && o_dbg_state == ST_IDLE && fifo_empty === 1'b1 &&
             tx_busy === 1'b0) && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    chk(tag, 32'(n < limit), 32'd1);
  endtask

  initial begin
    int s0;
    int peak;
    int n;
    int cnt;
    sys_rst   = 1'b1;
    recv_done = 1'b0;
    recv_data = 8'h00;
    repeat (3) @(negedge sys_clk);

    chk("rst_fill",      32'(fill_level),  32'd0);
    chk("rst_empty",     32'(fifo_empty),  32'd1);
    chk("rst_full",      32'(fifo_full),   32'd0);
    chk("rst_overflow",  32'(overflow),    32'd0);
    chk("rst_send_en",   32'(send_en),     32'd0);
    chk("rst_send_data", 32'(send_data),   32'd0);
    chk("rst_state",     32'(o_dbg_state), 32'(ST_IDLE));

    // Single byte, pushed on the very first edge after reset release.
    tx_mode  = 1;
    busy_len = 20;
    s0 = n_sends;
    sys_rst = 1'b0;
    push_byte(8'h55, 1'b1);
    chk("single_fill1",  32'(fill_level), 32'd1);
    chk("single_empty0", 32'(fifo_empty), 32'd0);
    @(negedge sys_clk);
    chk("single_no_early_en", 32'(send_en),    32'd0);
    chk("single_popped",      32'(fill_level), 32'd0);
    @(negedge sys_clk);
    chk("single_latency_en",   32'(send_en),   32'd1);
    chk("single_latency_data", 32'(send_data), 32'h55);
    wait_drain("single_drain", 200);
    chk("single_sends", 32'(n_sends - s0), 32'd1);
    chk("single_hold_data", 32'(send_data), 32'h55);

    // Burst of five back-to-back bytes while the transmitter is slow.
    busy_len = 30;
    s0 = n_sends;
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i), 1'b1);
      if (int'(fill_level) > peak) peak = int'(fill_level);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (int'(fill_level) > peak) peak = int'(fill_level);
    end
    chk("burst_peak", 32'(peak), 32'd4);
    wait_drain("burst_drain", 600);
    chk("burst_sends", 32'(n_sends - s0), 32'd5);

    // Pointer wrap: three full-depth chunks of incrementing data.
    busy_len = 3;
    s0 = n_sends;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < DEPTH; i++) push_byte(8'(c * DEPTH + i), 1'b1);
      wait_drain("wrap_drain", 1000);
    end
    chk("wrap_sends", 32'(n_sends - s0), 32'(3 * DEPTH));

    // Transmitter never reports busy: the FSM must time out of WAIT_BUSY.
    tx_mode = 0;
    s0 = n_sends;
    for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i), 1'b1);
    n = 0;
    while (!send_en && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("nobusy_first_en", 32'(send_en), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk("nobusy_in_wait_busy", 32'(o_dbg_state), 32'(ST_WAIT_BUSY));
    end
    @(negedge sys_clk);
    chk("nobusy_timeout_exit", 32'(o_dbg_state), 32'(ST_WAIT_DONE));
    wait_drain("nobusy_drain", 200);
    chk("nobusy_sends", 32'(n_sends - s0), 32'd3);

    // Randomized batches against the in-order byte queue.
    for (int b = 0; b < 6; b++) begin
      cnt      = int'($urandom_range(1, DEPTH));
      tx_mode  = int'($urandom_range(0, 2));
      busy_len = int'($urandom_range(1, 12));
      s0 = n_sends;
      for (int i = 0; i < cnt; i++) begin
        push_byte(8'($urandom), 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      end
      wait_drain("rand_drain", 3000);
      chk("rand_sends",    32'(n_sends - s0), 32'(cnt));
      chk("rand_fill",     32'(fill_level),   32'd0);
      chk("rand_overflow", 32'(overflow),     32'd0);
    end

    // Overflow: DEPTH+3 strobes, first byte popped, the last two dropped.
    tx_mode  = 1;
    busy_len = 60;
    s0 = n_sends;
    for (int i = 0; i < DEPTH + 3; i++) begin
      push_byte(8'hA0 + 8'(i), i <= DEPTH);
      if (i == DEPTH) begin
        chk("ovf_full",     32'(fifo_full),  32'd1);
        chk("ovf_fill",     32'(fill_level), 32'(DEPTH));
        chk("ovf_not_yet",  32'(overflow),   32'd0);
      end
      if (i == DEPTH + 1) chk("ovf_set", 32'(overflow), 32'd1);
    end
    chk("ovf_fill_after_drop", 32'(fill_level), 32'(DEPTH));
    wait_drain("ovf_drain", 3000);
    chk("ovf_sends",  32'(n_sends - s0), 32'(DEPTH + 1));
    chk("ovf_sticky", 32'(overflow),     32'd1);
    chk("ovf_empty",  32'(fifo_empty),   32'd1);

    // Reset while waiting for the transmitter with three bytes queued.
    busy_len = 40;
    for (int i = 0; i < 4; i++) push_byte(8'hC1 + 8'(i), 1'b1);
    n = 0;
    while (o_dbg_state != ST_WAIT_DONE && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("mid_in_wait_done", 32'(o_dbg_state), 32'(ST_WAIT_DONE));
    chk("mid_queued",       32'(fill_level),  32'd3);
    chk("mid_send_data",    32'(send_data),   32'hC1);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_fill",      32'(fill_level),  32'd0);
    chk("mid_rst_empty",     32'(fifo_empty),  32'd1);
    chk("mid_rst_full",      32'(fifo_full),   32'd0);
    chk("mid_rst_overflow",  32'(overflow),    32'd0);
    chk("mid_rst_send_en",   32'(send_en),     32'd0);
    chk("mid_rst_send_data", 32'(send_data),   32'd0);
    chk("mid_rst_state",     32'(o_dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge sys_clk);
    exp_q.delete();
    sys_rst = 1'b0;
    s0 = n_sends;
    repeat (60) @(negedge sys_clk);
    chk("mid_no_send", 32'(n_sends - s0), 32'd0);
    chk("mid_empty",   32'(fifo_empty),   32'd1);
    chk("mid_state",   32'(o_dbg_state),  32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
